lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_ext.sv | 23 ++
 rtl/lsu.sv | 125 ++++++++++++
 tb/tb_lsu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// access-width encodings and the d_mem byte-lane mask encodings.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] MASK_B = 2'b01;
   localparam logic [1:0] MASK_H = 2'b10;
   localparam logic [1:0] MASK_W = 2'b11;

   // Byte count of an access; the 11 encoding is illegal and faulted elsewhere.
   function automatic logic [2:0] access_size(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   access_size = 3'd1;
         2'b01:   access_size = 3'd2;
         default: access_size = 3'd4;
      endcase
   endfunction

   function automatic logic [1:0] access_mask(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   access_mask = MASK_B;
         2'b01:   access_mask = MASK_H;
         2'b10:   access_mask = MASK_W;
         default: access_mask = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatter: picks the low byte/half/word of the raw d_mem read
// data and sign- or zero-extends it according to the RV32I load funct3.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = '0;
      case (funct3)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_W:    ext = raw;
         F3_BU:   ext = {24'd0, raw[7:0]};
         F3_HU:   ext = {16'd0, raw[15:0]};
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEMORY_SIZE = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic [1:0]  mem_data_mask,
   output logic        mem_write_en,
   output logic        mem_read_en,
   input  logic [31:0] mem_read_data,
   output lsu_state_e  dbg_state
);

   // Both channels are valid/ready: a transfer happens on a rising clk edge
   // where valid & ready are both high; valid holds its payload until then.
   lsu_state_e  state, state_next;
   logic        req_fire, req_fault;
   logic        bad_funct3, out_of_range, misaligned;
   logic [32:0] end_addr;
   logic        cap_is_store, cap_fault;
   logic [2:0]  cap_funct3;
   logic [31:0] cap_addr, cap_wdata;
   logic [31:0] load_ext;

   assign dbg_state = state;

   always_comb begin
      req_ready  = (state == IDLE) | ((state == RESP) & resp_ready);
      req_fire   = req_valid & req_ready;
      state_next = state;
      case (state)
         IDLE:    if (req_fire) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (resp_ready) state_next = req_fire ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // 33-bit end address so a request near 0xFFFFFFFF cannot wrap into range.
   always_comb begin
      if (req_is_store)
         bad_funct3 = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
      else
         bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end_addr     = {1'b0, req_addr} + {30'd0, access_size(req_funct3[1:0])};
      out_of_range = end_addr > 33'(MEMORY_SIZE);
      misaligned   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
`endif
      req_fault = bad_funct3 | out_of_range | misaligned;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cap_is_store <= 1'b0;
         cap_fault    <= 1'b0;
         cap_funct3   <= '0;
         cap_addr     <= '0;
         cap_wdata    <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_fault   <= 1'b0;
      end else begin
         state <= state_next;
         if (req_fire) begin
            cap_is_store <= req_is_store;
            cap_fault    <= req_fault;
            cap_funct3   <= req_funct3;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
         end
         if (state == ACCESS) begin
            resp_valid <= 1'b1;
            resp_fault <= cap_fault;
            resp_rdata <= (cap_fault | cap_is_store) ? '0 : load_ext;
         end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

   // Faulted accesses still spend their ACCESS cycle but leave the port idle.
   always_comb begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_data_mask  = '0;
      mem_write_en   = 1'b0;
      mem_read_en    = 1'b0;
      if ((state == ACCESS) && !cap_fault) begin
         mem_addr       = cap_addr;
         mem_write_data = cap_wdata;
         mem_data_mask  = access_mask(cap_funct3[1:0]);
         mem_write_en   = cap_is_store & ~rst;
         mem_read_en    = ~cap_is_store;
      end
   end

   lsu_load_ext u_load_ext (
      .funct3 (cap_funct3),
      .raw    (mem_read_data),
      .ext    (load_ext)
   );

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array d_mem model, directed cases and
// randomized traffic scored against an access-level reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_data_mask;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;
  lsu_state_e  dbg_state;

  always #5 clk = ~clk;

  lsu #(.MEMORY_SIZE(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_data_mask(mem_data_mask),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state)
  );

  // d_mem model: combinational little-endian read, byte-lane write on posedge
  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  int         we_cnt = 0;

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++)
      if ({32'd0, mem_addr} + 64'(i) < 64'(MEM_BYTES))
        mem_read_data[8*i +: 8] = dmem[mem_addr[10:0] + 11'(i)];
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      int nb;
      we_cnt++;
      nb = (mem_data_mask == MASK_B) ? 1 : (mem_data_mask == MASK_H) ? 2 : 4;
      for (int i = 0; i < nb; i++)
        if ({32'd0, mem_addr} + 64'(i) < 64'(MEM_BYTES))
          dmem[mem_addr[10:0] + 11'(i)] = mem_write_data[8*i +: 8];
    end
  end

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {fault, rdata} of one access; stores update ref_mem
  function automatic logic [32:0] model(input logic st, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
    bit          legal;
    int          sz;
    logic [31:0] v;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!legal || ({32'd0, a} + 64'(sz) > 64'(MEM_BYTES))) return {1'b1, 32'd0};
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % sz) != 0) return {1'b1, 32'd0};
`endif
    if (st) begin
      for (int i = 0; i < sz; i++) ref_mem[a[10:0] + 11'(i)] = wd[8*i +: 8];
      return {1'b0, 32'd0};
    end
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a[10:0] + 11'(i)];
    case (f3)
      3'd0:    v = 32'(signed'(v[7:0]));
      3'd1:    v = 32'(signed'(v[15:0]));
      default: ;
    endcase
    return {1'b0, v};
  endfunction

  task automatic poke(input int a, input logic [7:0] b);
    dmem[a]    = b;
    ref_mem[a] = b;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request, wait for acceptance, leave it in the ACCESS cycle
  task automatic start_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    exp_q.push_back(model(st, f3, a, wd));
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("state_access", 32'(dbg_state), 32'(ACCESS));
  endtask

  // Wait for the response, hold it off for 'hold' cycles, then accept it
  task automatic finish_resp(input int hold);
    int          n;
    logic [32:0] exp;
    n = 0;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", 32'(n), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_DEAD;
    for (int i = 0; i < hold; i++) begin
      check("hold_rdata", resp_rdata, exp[31:0]);
      check("hold_fault", 32'(resp_fault), 32'(exp[32]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, exp[31:0]);
    check("resp_fault", 32'(resp_fault), 32'(exp[32]));
    resp_ready = 1'b1;
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_clear", 32'(resp_valid), 32'd0);
    check("state_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int w0;
    int bad;
    bit b2b;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < MEM_BYTES; i++) poke(i, 8'($urandom));
    reset_dut();

    // Reset state
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_ctrl", {27'd0, mem_data_mask, mem_write_en, mem_read_en}, 32'd0);

    // SW then LW
    start_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    finish_resp(0);
    release_resp();
    start_req(1'b0, F3_W, 32'h10, 32'h0);
    finish_resp(0);
    check("lw_deadbeef", resp_rdata, 32'hDEADBEEF);
    release_resp();

    // Sign vs zero extension
    poke(32'h20, 8'h80);
    start_req(1'b0, F3_B, 32'h20, 32'h0);
    finish_resp(0);
    check("lb_80", resp_rdata, 32'hFFFFFF80);
    release_resp();
    start_req(1'b0, F3_BU, 32'h20, 32'h0);
    finish_resp(0);
    check("lbu_80", resp_rdata, 32'h00000080);
    release_resp();

    // Misaligned half
    poke(32'h31, 8'h11);
    poke(32'h32, 8'h22);
    start_req(1'b1, F3_H, 32'h31, 32'h1234ABCD);
    finish_resp(0);
    release_resp();
    start_req(1'b0, F3_HU, 32'h31, 32'h0);
    finish_resp(0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lhu_mis_fault", 32'(resp_fault), 32'd1);
    check("mis_byte31", 32'(dmem[32'h31]), 32'h11);
    check("mis_byte32", 32'(dmem[32'h32]), 32'h22);
`else
    check("lhu_mis", resp_rdata, 32'h0000ABCD);
    check("mis_byte31", 32'(dmem[32'h31]), 32'hCD);
    check("mis_byte32", 32'(dmem[32'h32]), 32'hAB);
`endif
    release_resp();

    // Range boundary
    w0 = we_cnt;
    start_req(1'b1, F3_W, 32'h7FE, 32'hCAFEF00D);
    finish_resp(0);
    check("sw_7fe_fault", 32'(resp_fault), 32'd1);
    check("sw_7fe_no_write", 32'(we_cnt - w0), 32'd0);
    release_resp();
    poke(32'h7FF, 8'h7F);
    start_req(1'b0, F3_B, 32'h7FF, 32'h0);
    finish_resp(0);
    check("lb_7ff", {31'd0, resp_fault}, 32'd0);
    check("lb_7ff_data", resp_rdata, 32'h0000007F);
    release_resp();
    start_req(1'b0, F3_B, 32'hFFFFFFFF, 32'h0);
    finish_resp(0);
    check("lb_wrap_fault", 32'(resp_fault), 32'd1);
    release_resp();

    // Backpressure, then same-cycle accept of the next request
    start_req(1'b0, F3_W, 32'h10, 32'h0);
    finish_resp(5);
    start_req(1'b0, F3_BU, 32'h20, 32'h0);
    finish_resp(0);
    release_resp();

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1:       a = 32'h7F8 + 32'($urandom_range(0, 7));
        2:       a = 32'($urandom_range(0, MEM_BYTES - 1));
        default: a = 32'($urandom_range(0, 63));
      endcase
      start_req(st, f3, a, $urandom);
      finish_resp($urandom_range(0, 3));
      b2b = ($urandom_range(0, 1) == 1) && (t != 199);
      if (!b2b) release_resp();
    end

    // Reset during the ACCESS cycle of a store
    poke(32'h40, 8'hAA);
    req_is_store = 1'b1;
    req_funct3   = F3_B;
    req_addr     = 32'h40;
    req_wdata    = 32'h55;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_access", 32'(dbg_state), 32'(ACCESS));
    rst = 1'b1;
    #1;
    check("rst_we_gated", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_byte", 32'(dmem[32'h40]), 32'hAA);

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (dmem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
